// File: rtl/dct_it_lift_pipe.sv
// 8-point inverse binDCT-C (shift-add lifting) as an 8-stage valid/ready pipeline.
// Optional macro DCT_IT_SAT_EN: saturate output lanes and report clipping on out_sat.
module dct_it_lift_pipe #(
  parameter int W_I       = 16,
  parameter int W_O       = 16,
  parameter int FRAC      = 3,
  parameter int OUT_SHIFT = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0][W_I-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0][W_O-1:0]   out_data,
  output logic [7:0]            out_sat,
  output logic                  busy
);

  localparam int WI = W_I + FRAC + 3;

  typedef logic signed [WI-1:0] word_t;

  localparam word_t RND_HALF = word_t'(2 ** (FRAC - 1));
  localparam word_t RND_KEEP = ~word_t'(2 ** FRAC - 1);

  // Round to a multiple of 2^FRAC, half away from zero (symmetric on magnitude).
  function automatic word_t rnd(input word_t v);
    word_t mag;
    word_t q;
    mag = v[WI-1] ? -v : v;
    q   = (mag + RND_HALF) & RND_KEEP;
    return v[WI-1] ? -q : q;
  endfunction

  function automatic word_t ext(input logic [W_I-1:0] d);
    return word_t'($signed(d)) <<< FRAC;
  endfunction

  logic                en;
  logic [7:0]          vld;
  word_t               s0 [8];
  word_t               s1 [8];
  word_t               s2 [8];
  word_t               s3 [8];
  word_t               s4 [8];
  word_t               s5 [8];
  word_t               s6 [8];
  logic [7:0][W_O-1:0] lane_d;

  assign en        = ~out_valid | out_ready;
  assign in_ready  = en;
  assign out_valid = vld[7];
  assign busy      = |vld;

  // A flush or a stall-free edge moves the whole valid chain; clr drops a same-cycle input beat too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else if (clr) begin
      vld <= '0;
    end else if (en) begin
      vld <= {vld[6:0], in_valid};
    end
  end

  // NOTE: datapath flops carry no reset; the valid chain alone says which contents are real.
  always_ff @(posedge clk) begin
    if (en) begin
      // NOTE: non-blocking throughout, so every stage reads its predecessor's pre-edge value.
      s0[0] <= ext(in_data[0]);
      s0[1] <= ext(in_data[4]);
      s0[2] <= ext(in_data[6]);
      s0[3] <= ext(in_data[2]);
      s0[4] <= ext(in_data[7]);
      s0[5] <= ext(in_data[5]);
      s0[6] <= ext(in_data[3]);
      s0[7] <= ext(in_data[1]);

      s1[0] <= s0[0];
      s1[1] <= rnd(s0[0] >>> 1) - s0[1];
      s1[2] <= s0[2];
      s1[3] <= s0[3] - rnd((s0[2] >>> 3) + (s0[2] >>> 2));
      s1[4] <= s0[4];
      s1[5] <= s0[5];
      s1[6] <= rnd(s0[5] >>> 1) + s0[6];
      s1[7] <= s0[7];

      s2[0] <= s1[0] - s1[1];
      s2[1] <= s1[1];
      s2[2] <= s1[2] + rnd((s1[3] >>> 3) + (s1[3] >>> 2));
      s2[3] <= s1[3];
      s2[4] <= s1[4] + rnd(s1[7] >>> 3);
      s2[5] <= s1[5] - rnd((s1[6] >>> 3) + (s1[6] >>> 2) + (s1[6] >>> 1));
      s2[6] <= s1[6];
      s2[7] <= s1[7];

      s3[0] <= s2[0] + s2[3];
      s3[1] <= s2[1] + s2[2];
      s3[2] <= s2[1] - s2[2];
      s3[3] <= s2[0] - s2[3];
      s3[4] <= s2[4] + s2[5];
      s3[5] <= s2[4] - s2[5];
      s3[6] <= s2[7] - s2[6];
      s3[7] <= s2[6] + s2[7];

      s4    <= s3;
      s4[5] <= rnd((s3[6] >>> 3) + (s3[6] >>> 1)) - s3[5];

      s5    <= s4;
      s5[6] <= s4[6] - rnd((s4[5] >>> 3) + (s4[5] >>> 2));

      for (int i = 0; i < 4; i++) begin
        s6[i]     <= s5[i] + s5[7-i];
        s6[4 + i] <= s5[3-i] - s5[4 + i];
      end
    end
  end

`ifdef DCT_IT_SAT_EN
  localparam word_t SAT_MAX = word_t'(2 ** (W_O - 1) - 1);
  localparam word_t SAT_MIN = -SAT_MAX - word_t'(1);

  logic [7:0] sat_d;
  word_t      shifted;

  always_comb begin
    // NOTE: defaults first so every path assigns every bit; nothing here can become a latch.
    lane_d  = '0;
    sat_d   = '0;
    shifted = '0;
    for (int i = 0; i < 8; i++) begin
      shifted = s6[i] >>> OUT_SHIFT;
      if (shifted > SAT_MAX) begin
        lane_d[i] = SAT_MAX[W_O-1:0];
        sat_d[i]  = 1'b1;
      end else if (shifted < SAT_MIN) begin
        lane_d[i] = SAT_MIN[W_O-1:0];
        sat_d[i]  = 1'b1;
      end else begin
        lane_d[i] = shifted[W_O-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sat <= '0;
    end else if (en) begin
      out_sat <= sat_d;
    end
  end
`else
  always_comb begin
    lane_d = '0;
    for (int i = 0; i < 8; i++) begin
      lane_d[i] = W_O'(s6[i] >>> OUT_SHIFT);
    end
  end

  assign out_sat = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
    end else if (en) begin
      out_data <= lane_d;
    end
  end

endmodule
